// File: rtl/shift_pkg.sv
// Shared mode encoding for the universal shift register and its next-state logic.
// Latency: none (declarations only).
// Backpressure: not applicable.
package shift_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_LOAD = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_SHR  = 3'b011;
    localparam mode_t MODE_ROL  = 3'b100;
    localparam mode_t MODE_ROR  = 3'b101;
    localparam mode_t MODE_ASR  = 3'b110;
    localparam mode_t MODE_CLR  = 3'b111;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle between a driver and the universal shift register.
// Latency: none (wires only).
// Backpressure: none; en gates every update.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    import shift_pkg::*;

    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] d;
    logic             sin_lsb;
    logic             sin_msb;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_not;
    logic             sout_msb;
    logic             sout_lsb;
    logic             zero;

    modport master (
        output en, mode, d, sin_lsb, sin_msb,
        input  q, q_not, sout_msb, sout_lsb, zero
    );

    modport slave (
        input  en, mode, d, sin_lsb, sin_msb,
        output q, q_not, sout_msb, sout_lsb, zero
    );

endinterface

// File: rtl/shift_next.sv
// Next-value selector for the shift register: load, shifts, rotates, clear.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to commit the value.
module shift_next
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] nxt
);

    // Select the candidate value; serial inputs and d only matter in their own modes.
    always_comb begin
        nxt = q;
        case (mode)
            MODE_HOLD: nxt = q;
            MODE_LOAD: nxt = d;
            MODE_SHL:  nxt = {q[WIDTH-2:0], sin_lsb};
            MODE_SHR:  nxt = {sin_msb, q[WIDTH-1:1]};
            MODE_ROL:  nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  nxt = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  nxt = '0;
            default:   nxt = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit storage/serialiser register with load, shift, rotate and clears.
// Latency: one clock from a qualified edge to the new q.
// Backpressure: en=0 holds q for every mode, including clear.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [63:0] RESET_VAL = 64'd0
) (
    input  logic                clk,
    input  logic                reset,
    univ_shift_reg_if.slave     bus
);

    // Reset value is cut down to the register width.
    localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] nxt;

    shift_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q       (q_r),
        .mode    (bus.mode),
        .d       (bus.d),
        .sin_lsb (bus.sin_lsb),
        .sin_msb (bus.sin_msb),
        .nxt     (nxt)
    );

    // Storage: async clear to RESET_VAL, otherwise commit the next value when enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r <= RST_V;
        end else if (bus.en) begin
            q_r <= nxt;
        end
    end

    assign bus.q        = q_r;
    assign bus.q_not    = ~q_r;
    assign bus.sout_msb = q_r[WIDTH-1];
    assign bus.sout_lsb = q_r[0];
    assign bus.zero     = ~|q_r;

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register built on the same storage idiom (clock edge, asynchronous active-low clear, true and complemented outputs).
- Adds the following:
  - clock enable
  - parallel load
  - logical, arithmetic and rotate shifts
  - synchronous clear
  - serial in/out at both ends
  - a programmable reset value
- Used as the general-purpose storage/serialiser element in datapaths and bit-serial interfaces.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, 0, value q takes while reset is low; truncated to WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset; q forced to RESET_VAL immediately, held while low.
- en  input  1  clock enable; 0 = hold regardless of mode.
- mode  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- sin_lsb  input  1  serial bit entering at bit 0 on shift-left.
- sin_msb  input  1  serial bit entering at bit WIDTH-1 on logical shift-right.
- q  output  WIDTH  register contents.
- q_not  output  WIDTH  bitwise complement of q, combinational.
- sout_msb  output  1  equals q[WIDTH-1], combinational.
- sout_lsb  output  1  equals q[0], combinational.
- zero  output  1  1 when q is all zeros, combinational.

Behaviour:
- Reset: asynchronous, active-low. While reset=0:
  - q=RESET_VAL and q_not=~RESET_VAL.
  - sout_msb/sout_lsb/zero follow from RESET_VAL.
- Reset assertion mid-operation overrides any in-progress update with no clock edge required.
- Reset release is synchronous in effect: the first update occurs on the first rising clk edge with reset=1.
- Update: on rising clk with reset=1 and en=1, q takes the next value selected by mode. Latency is one cycle; the new q is visible after the edge.
- en=0: q holds for every mode, including clear.
- Mode encoding:
  - 000 HOLD: q unchanged.
  - 001 LOAD: q <= d.
  - 010 SHL: q <= {q[WIDTH-2:0], sin_lsb}.
  - 011 SHR: q <= {sin_msb, q[WIDTH-1:1]}.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; serial inputs ignored.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}; serial inputs ignored.
  - 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; sign bit replicated, sin_msb ignored.
  - 111 CLR: q <= 0 synchronously. This is not RESET_VAL; it differs from async reset when RESET_VAL is nonzero.
- Serial out: sout_msb/sout_lsb show the current q, i.e. the bit about to be shifted out. A bench samples them before the edge.
- Boundary cases:
  - Rotate by WIDTH consecutive cycles returns the original value.
  - SHL/SHR by WIDTH cycles with constant serial input fills the register entirely with that input.
  - ASR on a negative value converges to all ones; on a positive value it converges to 0.
- No X propagation from unused inputs: d is ignored unless mode=LOAD, and serial inputs are ignored except in SHL/SHR.
- Unknown/X mode: q is undefined in simulation only. No recovery logic is required; all 8 codes are legal.

Decomposition:
- Shared package shift_pkg holds:
  - the mode localparams MODE_HOLD..MODE_CLR (3-bit);
  - a mode_t typedef, if SystemVerilog is permitted.
- One optional combinational sub-module, shift_next, computes the next value from (q, mode, d, sin_lsb, sin_msb).
- The top contains only the async-reset register, the enable mux and the output assigns.

Test Plan:
- Reset check: WIDTH=8, RESET_VAL=8'hA5; hold reset=0 two cycles, then release.
  - q=A5, q_not=5A, zero=0 during reset.
  - q stays A5 after release with mode=HOLD.
- Load and async reset: LOAD d=8'h3C, then pull reset low mid-cycle (between edges).
  - q=3C one cycle after the load.
  - q=A5 immediately on reset, without waiting for an edge.
- Logical shifts: q=8'h81.
  - SHL with sin_lsb=1 gives q=03.
  - Then SHR with sin_msb=0 gives q=01.
  - sout_msb=1 before the first edge.
- Rotates: q=8'h96.
  - ROL x8 returns q=96; after the first ROL q=2D.
  - ROR once from 96 gives 4B.
- ASR: q=8'h80; 7 cycles of ASR give q=FF. Then q=8'h40; 7 cycles of ASR give q=00 with zero=1.
- Enable and clear: en=0 with mode=CLR on q=5A keeps q=5A. Then en=1 with CLR gives q=00, not A5.
